branch_pc_unit: RTL and testbench
=================================

# branch_pc_unit

Fetch-stage program-counter generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It replaces fixed "current PC + 2" sequencing with predicted next-PC selection at fetch. Resolved branch and jump outcomes from execute train the table and redirect the PC on a misprediction. It sits between instruction memory addressing and the IF/ID register and drives the flush signal for younger pipeline stages.

## Interface

Parameters:
- PC_W, 16, PC and target width in bits.
- BTB_DEPTH, 16, number of BTB entries; power of two, at least 2. IDX_W = log2(BTB_DEPTH).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  hold the PC (hazard or memory busy).
- res_valid  in  1  a resolved control-transfer record is present this cycle.
- res_is_branch  in  1  the record is a branch or jump (trains the BTB).
- res_pc  in  PC_W  PC of the resolved instruction.
- res_taken  in  1  actual direction; must be 1 for unconditional jumps.
- res_target  in  PC_W  actual target when taken.
- res_pred_taken  in  1  prediction made at fetch, carried down the pipe.
- res_pred_target  in  PC_W  predicted target made at fetch, carried down the pipe.
- fetch_pc  out  PC_W  registered current PC.
- pred_taken  out  1  BTB hit with counter MSB = 1 for fetch_pc.
- pred_target  out  PC_W  BTB target for fetch_pc; valid only when pred_taken = 1.
- next_pc  out  PC_W  combinational value the PC will take at the next edge.
- flush  out  1  combinational misprediction pulse; squash younger stages.

## Operation

- Instructions are 2-byte aligned, so bit 0 of the PC is ignored.
- Index = pc[IDX_W:1]. Tag = pc[PC_W-1:IDX_W+1].
- Each entry holds: valid, tag, target[PC_W], and a 2-bit counter.
- Lookup is combinational on fetch_pc:
  - hit = valid[idx] && tag matches.
  - pred_taken = hit && cnt[1].
  - pred_target = target[idx].
- Misprediction: mispredict = res_valid && res_is_branch && ((res_taken != res_pred_taken) || (res_taken && res_target != res_pred_target)).
  - flush = mispredict.
  - redirect = res_taken ? res_target : res_pc + 2.
- next_pc, highest priority first:
  1. redirect, if mispredict.
  2. fetch_pc, if stall.
  3. pred_target, if pred_taken.
  4. fetch_pc + 2.
- Arithmetic is modulo 2^PC_W: 0xFFFE + 2 = 0x0000.
- Training happens at the edge when res_valid && res_is_branch, at the entry indexed by res_pc:
  - Tag hit: the counter increments on taken and decrements on not-taken, saturating at 11 and 00. Target is written with res_target when taken.
  - Miss and taken: allocate the entry (overwrite): valid = 1, tag, target = res_target, cnt = 10 (weakly taken).
  - Miss and not-taken: no change.
- Training is independent of stall and occurs in stalled cycles too.
- Records with res_valid = 1 and res_is_branch = 0 are ignored entirely.

## Timing

- Reset, asynchronous: fetch_pc = RESET_PC, all valid = 0, all counters = 01.
  - While rst is high: pred_taken = 0, flush = 0, next_pc = RESET_PC.
  - The first fetch after deassertion is at RESET_PC.
  - Reset mid-operation aborts any pending redirect and any training write.
- fetch_pc updates to next_pc at each rising edge. The prediction is used in the same cycle as the lookup, with zero bubbles on a correct taken prediction.
- Misprediction costs one edge: flush is high in the resolve cycle, and fetch_pc = redirect after that edge.
- A lookup and a training write to the same index in the same cycle: the lookup sees the pre-edge contents, and the new contents are visible from the next cycle.
- Redirect overrides stall in the same cycle.
- Back-to-back resolves are allowed, one per cycle.

## Test plan

All scenarios use PC_W = 16, BTB_DEPTH = 4, RESET_PC = 0.

- **Reset and sequencing.** Assert rst for 2 cycles, then release with stall = 0 -> fetch_pc steps 0x0000, 0x0002, 0x0004, 0x0006 and pred_taken stays 0. Assert rst asynchronously mid-cycle -> fetch_pc = 0x0000 immediately.
- **Mispredict, allocate, then predict.** Drive res_pc = 0x0004, taken, target 0x0020, pred_taken = 0 -> flush = 1, next fetch_pc = 0x0020, entry 2 gets cnt = 10. Later, fetch_pc = 0x0004 -> pred_taken = 1, pred_target = 0x0020, next fetch_pc = 0x0020, flush = 0.
- **Counter hysteresis.** From cnt = 10 at entry 2:
  - Taken twice -> cnt = 11.
  - Not-taken once -> cnt = 10, still predicts taken.
  - Not-taken again, reported as mispredicted -> cnt = 01, flush = 1, redirect to 0x0006.
  - Fetch at 0x0004 -> pred_taken = 0.
- **Stall and priority.** stall = 1 for 3 cycles at 0x0010 -> fetch_pc holds 0x0010. stall = 1 together with a mispredict to 0x0040 -> fetch_pc = 0x0040 on the next edge.
- **Aliasing and wrap.** With entry 2 holding the tag of 0x0004, fetch 0x000C -> pred_taken = 0. Redirect to 0xFFFE, no stall -> next fetch_pc = 0x0000.
- **Target change.** Entry for 0x0004 predicts 0x0020; resolve taken to 0x0030 with res_pred_target = 0x0020 -> flush = 1, fetch_pc = 0x0030, stored target = 0x0030.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Fetch-stage PC generator: direct-mapped BTB with 2-bit direction counters,
// trained by resolved branches from execute, which also redirect on mispredict.
module branch_pc_unit #(
  parameter int              PC_W      = 16,
  parameter int              BTB_DEPTH = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            res_valid,
  input  logic            res_is_branch,
  input  logic [PC_W-1:0] res_pc,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [PC_W-1:0] res_pred_target,
  output logic [PC_W-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  output logic [PC_W-1:0] next_pc,
  output logic            flush
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 1;

  logic [PC_W-1:0]      fetch_pc_q;
  logic [BTB_DEPTH-1:0] valid_q;
  logic [1:0]           cnt_q [BTB_DEPTH];
  logic [TAG_W-1:0]     tag_q [BTB_DEPTH];
  logic [PC_W-1:0]      tgt_q [BTB_DEPTH];

  logic [IDX_W-1:0] lk_idx, trn_idx;
  logic [TAG_W-1:0] lk_tag, trn_tag;
  logic             lk_hit, trn_en, trn_hit, mispredict;
  logic [PC_W-1:0]  redirect;

  function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    else    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Lookup on the registered fetch PC; bit 0 is ignored (2-byte aligned)
  assign lk_idx      = fetch_pc_q[IDX_W:1];
  assign lk_tag      = fetch_pc_q[PC_W-1:IDX_W+1];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = !rst && lk_hit && cnt_q[lk_idx][1];
  assign pred_target = tgt_q[lk_idx];
  assign fetch_pc    = fetch_pc_q;

  assign trn_idx = res_pc[IDX_W:1];
  assign trn_tag = res_pc[PC_W-1:IDX_W+1];
  assign trn_en  = res_valid && res_is_branch;
  assign trn_hit = valid_q[trn_idx] && (tag_q[trn_idx] == trn_tag);

  assign mispredict = !rst && trn_en &&
                      ((res_taken != res_pred_taken) ||
                       (res_taken && (res_target != res_pred_target)));
  assign flush      = mispredict;
  assign redirect   = res_taken ? res_target : res_pc + PC_W'(2);

  always_comb begin
    next_pc = fetch_pc_q + PC_W'(2);
    if (rst)             next_pc = RESET_PC;
    else if (mispredict) next_pc = redirect;
    else if (stall)      next_pc = fetch_pc_q;
    else if (pred_taken) next_pc = pred_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      valid_q    <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) cnt_q[i] <= 2'b01;
    end else begin
      fetch_pc_q <= next_pc;
      if (trn_en) begin
        if (trn_hit) begin
          cnt_q[trn_idx] <= sat_cnt(cnt_q[trn_idx], res_taken);
        end else if (res_taken) begin
          valid_q[trn_idx] <= 1'b1;
          cnt_q[trn_idx]   <= 2'b10;
        end
      end
    end
  end

  // Tag/target payload needs no reset: it is only trusted behind valid_q
  always_ff @(posedge clk) begin
    if (trn_en && res_taken && !rst) begin
      tag_q[trn_idx] <= trn_tag;
      tgt_q[trn_idx] <= res_target;
    end
  end
endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with a behavioural BTB/PC model checked every cycle.
module tb_branch_pc_unit;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic        res_valid = 1'b0, res_is_branch = 1'b0, res_taken = 1'b0, res_pred_taken = 1'b0;
  logic [15:0] res_pc = '0, res_target = '0, res_pred_target = '0;
  logic [15:0] fetch_pc, pred_target, next_pc;
  logic        pred_taken, flush;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  branch_pc_unit #(.PC_W(16), .BTB_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_pc(res_pc),
    .res_taken(res_taken), .res_target(res_target),
    .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .next_pc(next_pc), .flush(flush)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: 4 entries, index = (pc/2) mod 4, tag = pc/8
  int m_pc;
  bit m_v [4];
  int m_tag [4], m_tgt [4], m_cnt [4];

  function automatic int m_idx(input int pc);
    return (pc / 2) % 4;
  endfunction

  function automatic bit m_ptaken();
    int i = m_idx(m_pc);
    return !rst && m_v[i] && (m_tag[i] == m_pc / 8) && (m_cnt[i] >= 2);
  endfunction

  function automatic bit m_mis();
    return !rst && res_valid && res_is_branch &&
           ((res_taken != res_pred_taken) || (res_taken && res_target != res_pred_target));
  endfunction

  function automatic int m_next();
    if (rst)        return 0;
    if (m_mis())    return res_taken ? int'(res_target) : (int'(res_pc) + 2) % 65536;
    if (stall)      return m_pc;
    if (m_ptaken()) return m_tgt[m_idx(m_pc)];
    return (m_pc + 2) % 65536;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 0;
      for (int i = 0; i < 4; i++) begin m_v[i] <= 1'b0; m_cnt[i] <= 1; end
    end else begin
      m_pc <= m_next();
      if (res_valid && res_is_branch) begin
        if (m_v[m_idx(int'(res_pc))] && m_tag[m_idx(int'(res_pc))] == int'(res_pc) / 8) begin
          if (res_taken) begin
            m_cnt[m_idx(int'(res_pc))] <= (m_cnt[m_idx(int'(res_pc))] == 3) ? 3 : m_cnt[m_idx(int'(res_pc))] + 1;
            m_tgt[m_idx(int'(res_pc))] <= int'(res_target);
          end else begin
            m_cnt[m_idx(int'(res_pc))] <= (m_cnt[m_idx(int'(res_pc))] == 0) ? 0 : m_cnt[m_idx(int'(res_pc))] - 1;
          end
        end else if (res_taken) begin
          m_v[m_idx(int'(res_pc))]   <= 1'b1;
          m_tag[m_idx(int'(res_pc))] <= int'(res_pc) / 8;
          m_tgt[m_idx(int'(res_pc))] <= int'(res_target);
          m_cnt[m_idx(int'(res_pc))] <= 2;
        end
      end
    end
  end

  // Per-cycle comparison against the model, on the falling edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("cyc_fetch_pc", fetch_pc, m_pc);
      chk("cyc_pred_taken", pred_taken, m_ptaken());
      if (m_ptaken()) chk("cyc_pred_target", pred_target, m_tgt[m_idx(m_pc)]);
      chk("cyc_next_pc", next_pc, m_next());
      chk("cyc_flush", flush, m_mis());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic res(input logic [15:0] pc, input logic tk, input logic [15:0] tgt,
                     input logic ptk, input logic [15:0] ptgt);
    res_valid = 1'b1; res_is_branch = 1'b1; res_pc = pc; res_taken = tk;
    res_target = tgt; res_pred_taken = ptk; res_pred_target = ptgt;
  endtask

  task automatic noop();
    res_valid = 1'b0; res_is_branch = 1'b0; res_pc = '0; res_taken = 1'b0;
    res_target = '0; res_pred_taken = 1'b0; res_pred_target = '0;
  endtask

  // Reach pc via a mispredicted not-taken record at pc-2 (never trains the BTB)
  task automatic goto(input logic [15:0] pc);
    res(pc - 16'd2, 1'b0, 16'h0, 1'b1, 16'h0);
    cyc();
    noop();
    #2;
  endtask

  initial begin
    // Reset and sequencing
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2 chk("rst_fetch", fetch_pc, 16'h0000);
    chk("rst_pred", pred_taken, 0);
    cyc(); #2 chk("seq_2", fetch_pc, 16'h0002);
    cyc(); #2 chk("seq_4", fetch_pc, 16'h0004);
    cyc(); #2 chk("seq_6", fetch_pc, 16'h0006);
    chk("seq_pred", pred_taken, 0);
    rst = 1'b1;
    #1 chk("arst_fetch", fetch_pc, 16'h0000);
    chk("arst_next", next_pc, 16'h0000);
    chk("arst_flush", flush, 0);
    cyc(); rst = 1'b0;
    #2 chk("arst_after", fetch_pc, 16'h0000);

    // Mispredict allocates entry 2
    res(16'h0004, 1'b1, 16'h0020, 1'b0, 16'h0);
    #2 chk("alloc_flush", flush, 1);
    chk("alloc_next", next_pc, 16'h0020);
    cyc(); noop();
    #2 chk("alloc_fetch", fetch_pc, 16'h0020);

    // Non-branch record is ignored
    res_valid = 1'b1; res_taken = 1'b1; res_target = 16'h0100;
    #2 chk("nonbr_flush", flush, 0);
    chk("nonbr_next", next_pc, 16'h0022);
    cyc(); noop();

    goto(16'h0004);
    chk("pred_taken", pred_taken, 1);
    chk("pred_target", pred_target, 16'h0020);
    chk("pred_next", next_pc, 16'h0020);
    chk("pred_flush", flush, 0);
    cyc(); #2 chk("pred_fetch", fetch_pc, 16'h0020);

    // Counter hysteresis: 10 -> 11 -> 11 -> 10 -> 01
    res(16'h0004, 1'b1, 16'h0020, 1'b1, 16'h0020);
    #2 chk("hyst_ok_flush", flush, 0);
    cyc(); cyc(); noop();
    res(16'h0004, 1'b0, 16'h0, 1'b0, 16'h0);
    cyc(); noop();
    goto(16'h0004);
    chk("hyst_still_taken", pred_taken, 1);
    res(16'h0004, 1'b0, 16'h0, 1'b1, 16'h0020);
    #2 chk("hyst_mis_flush", flush, 1);
    chk("hyst_mis_next", next_pc, 16'h0006);
    cyc(); noop();
    #2 chk("hyst_fetch6", fetch_pc, 16'h0006);
    goto(16'h0004);
    chk("hyst_not_taken", pred_taken, 0);
    chk("hyst_seq_next", next_pc, 16'h0006);

    // Stall and priority
    goto(16'h0010);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #2 chk("stall_hold", fetch_pc, 16'h0010);
    end
    res(16'h0008, 1'b1, 16'h0040, 1'b0, 16'h0);
    #2 chk("stall_mis_next", next_pc, 16'h0040);
    cyc(); stall = 1'b0; noop();
    #2 chk("stall_mis_fetch", fetch_pc, 16'h0040);

    // Aliasing and wrap
    goto(16'h000C);
    chk("alias_pred", pred_taken, 0);
    chk("alias_next", next_pc, 16'h000E);
    goto(16'hFFFE);
    chk("wrap_fetch", fetch_pc, 16'hFFFE);
    chk("wrap_next", next_pc, 16'h0000);
    cyc(); #2 chk("wrap_after", fetch_pc, 16'h0000);

    // Target change (entry at 01 -> 10 first so it predicts taken again)
    res(16'h0004, 1'b1, 16'h0020, 1'b0, 16'h0);
    cyc(); noop();
    goto(16'h0004);
    chk("tc_pred", pred_taken, 1);
    res(16'h0004, 1'b1, 16'h0030, 1'b1, 16'h0020);
    #2 chk("tc_old_target", pred_target, 16'h0020);
    chk("tc_flush", flush, 1);
    chk("tc_next", next_pc, 16'h0030);
    cyc(); noop();
    #2 chk("tc_fetch", fetch_pc, 16'h0030);
    goto(16'h0004);
    chk("tc_new_target", pred_target, 16'h0030);
    chk("tc_new_pred", pred_taken, 1);

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
